// File: rtl/dm_pkg.sv
// Shared encodings, request record and alignment helper for the sub-word data memory.
package dm_pkg;
  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_BUSY, ST_RESP} dm_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dm_req_t;

  // Undefined op codes fall into the word rule.
  function automatic logic dm_is_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      DM_H, DM_HU: return a[0];
      DM_B, DM_BU: return 1'b0;
      default:     return a != 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane store merge and load extract/extend; one instance serves both write and read paths.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] loaded_o
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] be;
  logic [31:0]          wrep;
  logic [31:0]          bsh, hsh;

  always_comb begin
    be   = '1;
    wrep = wdata_i;
    case (op_i)
      DM_B, DM_BU: begin
        be   = 4'b0001 << lane_i;
        wrep = {4{wdata_i[7:0]}};
      end
      DM_H, DM_HU: begin
        be   = lane_i[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign merged_o[8*g +: 8] = be[g] ? wrep[8*g +: 8] : word_i[8*g +: 8];
  end

  assign bsh = word_i >> {lane_i, 3'b000};
  assign hsh = word_i >> {lane_i[1], 4'b0000};

  always_comb begin
    loaded_o = word_i;
    case (op_i)
      DM_B:    loaded_o = {{24{bsh[7]}}, bsh[7:0]};
      DM_BU:   loaded_o = {24'b0, bsh[7:0]};
      DM_H:    loaded_o = {{16{hsh[15]}}, hsh[15:0]};
      DM_HU:   loaded_o = {16'b0, hsh[15:0]};
      default: ;
    endcase
  end
endmodule

// File: rtl/dm_subword_mem.sv
// Byte/half/word data memory with req/ready/rvalid handshake, fixed latency and post-reset clear.
// Define DM_TRACE_EN to print a trace line for every committed store.
module dm_subword_mem
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1,
  parameter int          CLEAR_WORDS = 3072,
  parameter logic [31:0] PC_OFFSET   = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int                ADDR_W   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);
  localparam logic [3:0]        LAT_M1   = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [3:0]        cnt_q, cnt_d;
  dm_req_t           req_q, req_d, src;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] idx_s;
  logic              err_c, resp_next;
  logic [31:0]       rd_word, merged, loaded;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [31:0]       mem_wdata;

  // In IDLE the live inputs drive the datapath so LATENCY=1 can respond next cycle.
  assign src     = (state_q == ST_IDLE) ? {we, op, addr, wdata, pc} : req_q;
  assign idx_s   = src.addr[ADDR_W+1:2];
  assign err_c   = (|(src.addr >> (ADDR_W + 2))) | dm_is_misaligned(src.op, src.addr[1:0]);
  assign rd_word = mem[idx_s];

  dm_lane_align u_align (
    .op_i     (src.op),
    .lane_i   (src.addr[1:0]),
    .word_i   (rd_word),
    .wdata_i  (src.wdata),
    .merged_o (merged),
    .loaded_o (loaded)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == CLR_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req) begin
          req_d   = src;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
    resp_next = (state_d == ST_RESP);
    rvalid_d  = resp_next;
    err_d     = resp_next & err_c;
    rdata_d   = (resp_next && !src.we && !err_c) ? loaded : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      cnt_q     <= '0;
      req_q     <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Stores commit on the edge leaving RESP; err_q already holds that access's error.
  assign mem_we    = (state_q == ST_CLEAR) || (state_q == ST_RESP && req_q.we && !err_q);
  assign mem_widx  = (state_q == ST_CLEAR) ? clr_idx_q : idx_s;
  assign mem_wdata = (state_q == ST_CLEAR) ? 32'h0 : merged;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign ready  = (state_q == ST_IDLE);
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset_n && state_q == ST_RESP && req_q.we && !err_q)
      $display("%d@%h: *%h <= %h", $time, req_q.pc + PC_OFFSET,
               {req_q.addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^{req_q.pc, PC_OFFSET};
`endif
endmodule

// File: tb/tb_dm_subword_mem.sv
// Randomized self-checking bench for dm_subword_mem against a word-array reference model.
module tb_dm_subword_mem;
  import dm_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;
  localparam int CLR   = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0, pc = '0;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  int nchk = 0;
  int nfail = 0;
  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  dm_subword_mem #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .CLEAR_WORDS (CLR),
    .PC_OFFSET   (32'h0000_3000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .op      (op),
    .addr    (addr),
    .wdata   (wdata),
    .pc      (pc),
    .ready   (ready),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: plain shift/mask arithmetic on a whole word.
  function automatic bit m_err(input logic [2:0] o, input logic [31:0] a);
    bit mis;
    if (o == DM_H || o == DM_HU)      mis = a[0];
    else if (o == DM_B || o == DM_BU) mis = 1'b0;
    else                              mis = (a % 4) != 0;
    return mis || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] o, input int lane, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * (lane / 2))) & 32'hFFFF;
    case (o)
      DM_B:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      DM_BU:   return b;
      DM_H:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      DM_HU:   return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] o, input int lane, input logic [31:0] w,
                                          input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (o == DM_B || o == DM_BU) begin
      sh = 8 * lane; m = 32'hFF << sh;
    end else if (o == DM_H || o == DM_HU) begin
      sh = 16 * (lane / 2); m = 32'hFFFF << sh;
    end else return d;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  task automatic do_reset();
    int n;
    reset_n = 1'b0;
    req = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("clear_cycles", n, CLR);
    @(negedge clk);
    for (int i = 0; i < CLR; i++) mdl[i] = 32'h0;
  endtask

  task automatic xact(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                      input bit hold, input string tag, output logic [31:0] rd);
    int t, nv, vat, wi;
    logic e;
    bit rdy_bad, idle_bad, exp_e;
    logic [31:0] exp_rd;
    t = 0;
    while (!ready && t < 100) begin
      @(negedge clk); t++;
    end
    chk({tag, ".ready_in"}, ready, 1);
    req = 1'b1; we = w; op = o; addr = a; wdata = wd; pc = $urandom;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req = 1'b0;
    nv = 0; vat = 0; rd = '0; e = 1'b0; rdy_bad = 0; idle_bad = 0;
    for (int c = 1; c <= LAT + 1; c++) begin
      if (c > 1) @(negedge clk);
      if (rvalid) begin
        nv++; vat = c; rd = rdata; e = err;
      end else if (rdata !== 32'h0 || err !== 1'b0) idle_bad = 1;
      if (c <= LAT && ready) rdy_bad = 1;
    end
    req = 1'b0;
    chk({tag, ".nvalid"}, nv, 1);
    chk({tag, ".latency"}, vat, LAT);
    chk({tag, ".busy_ready"}, {31'b0, rdy_bad}, 0);
    chk({tag, ".ready_after"}, ready, 1);
    chk({tag, ".idle_out"}, {31'b0, idle_bad}, 0);
    exp_e  = m_err(o, a);
    wi     = int'((a / 4) % DEPTH);
    exp_rd = (w || exp_e) ? 32'h0 : m_load(o, int'(a % 4), mdl[wi]);
    chk({tag, ".err"}, {31'b0, e}, {31'b0, exp_e});
    chk({tag, ".rdata"}, rd, exp_rd);
    if (w && !exp_e) mdl[wi] = m_store(o, int'(a % 4), mdl[wi], wd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, d;
    logic [2:0]  o;
    logic        w;
    int          n;

    @(negedge clk);
    do_reset();

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) xact(1, DM_W, 32'(i * 4), $urandom, 0, "init", rd);

    // Clear sweep zeroes low words only; upper words survive reset.
    xact(1, DM_W, 32'hC, 32'hDEADBEEF, 0, "pre_c", rd);
    xact(0, DM_W, 32'hC, 0, 0, "pre_c_rd", rd);
    chk("pre_c_val", rd, 32'hDEADBEEF);
    xact(1, DM_W, 32'h50, 32'hA5A5_0001, 0, "pre_50", rd);
    do_reset();
    xact(0, DM_W, 32'hC, 0, 0, "clr_c", rd);
    chk("clr_c_val", rd, 32'h0);
    xact(0, DM_W, 32'h50, 0, 0, "keep_50", rd);
    chk("keep_50_val", rd, 32'hA5A5_0001);

    // Store merge.
    xact(1, DM_W, 32'h10, 32'h12345678, 0, "sw10", rd);
    xact(1, DM_B, 32'h11, 32'h000000AB, 0, "sb11", rd);
    xact(0, DM_W, 32'h10, 0, 0, "lw10", rd);
    chk("merge_val", rd, 32'h1234AB78);
    xact(1, DM_H, 32'h12, 32'hFFFF_CAFE, 0, "sh12", rd);
    xact(0, DM_W, 32'h10, 0, 0, "lw10b", rd);
    chk("merge_h_val", rd, 32'hCAFEAB78);

    // Load extension.
    xact(1, DM_W, 32'h20, 32'h80FF7F01, 0, "sw20", rd);
    xact(0, DM_B, 32'h22, 0, 0, "lb22", rd);
    chk("lb22_val", rd, 32'hFFFFFFFF);
    xact(0, DM_BU, 32'h23, 0, 0, "lbu23", rd);
    chk("lbu23_val", rd, 32'h00000080);
    xact(0, DM_H, 32'h22, 0, 0, "lh22", rd);
    chk("lh22_val", rd, 32'hFFFF80FF);
    xact(0, DM_HU, 32'h20, 0, 0, "lhu20", rd);
    chk("lhu20_val", rd, 32'h00007F01);

    // Error cases leave memory untouched.
    xact(1, DM_H, 32'h21, 32'h1111, 0, "sh21", rd);
    xact(1, DM_W, 32'(DEPTH * 4), 32'h2222_2222, 0, "sw_oor", rd);
    xact(1, DM_W, 32'h22, 32'h3333_3333, 0, "sw_mis", rd);
    xact(0, DM_W, 32'h20, 0, 0, "lw20", rd);
    chk("err_nowrite", rd, 32'h80FF7F01);
    xact(0, 3'd6, 32'h20, 0, 0, "undef_op", rd);
    chk("undef_op_val", rd, 32'h80FF7F01);

    // req held high through the access still yields a single response.
    xact(0, DM_W, 32'h10, 0, 1, "hold", rd);
    chk("hold_val", rd, 32'hCAFEAB78);

    // Reset during BUSY on a store abandons it.
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk); n++;
    end
    req = 1'b1; we = 1'b1; op = DM_W; addr = 32'h50; wdata = 32'h0BAD0BAD;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("busy_ready", ready, 0);
    do_reset();
    xact(0, DM_W, 32'h50, 0, 0, "abort_50", rd);
    chk("abort_50_val", rd, 32'hA5A5_0001);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(DEPTH * 4) + $urandom_range(0, 255);
        1:       a = $urandom;
        default: a = $urandom_range(0, DEPTH * 4 - 1);
      endcase
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      xact(w, o, a, d, 1'($urandom_range(0, 1)), "rnd", rd);
    end

    // Read back the whole model.
    for (int i = 0; i < DEPTH; i++) xact(0, DM_W, 32'(i * 4), 0, 0, "final", rd);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/dm_subword_mem.md
# dm_subword_mem

Parametrised data memory for the single-issue MIPS core. It replaces the word-only DM with byte, halfword and word loads and stores, sign or zero extension, and alignment and range checking. It uses a req/ready/rvalid handshake with a configurable access latency, and runs a post-reset clear sweep. It sits in the MEM stage; the pipeline stalls while `ready` is low.

## Interface
Parameters:
- `DEPTH_WORDS`, default 4096: memory depth in 32-bit words; must be a power of two.
- `LATENCY`, default 1: cycles from request acceptance to response; allowed range 1..15.
- `CLEAR_WORDS`, default 3072: number of words, starting at index 0, zeroed by the post-reset sweep; must be ≤ `DEPTH_WORDS`.
- `PC_OFFSET`, default 32'h0000_3000: added to `pc` for the trace line.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 1: request valid; sampled only when `ready`=1.
- `we`, in, 1: 1 = store, 0 = load.
- `op`, in, 3: access type, `DM_W`/`DM_H`/`DM_HU`/`DM_B`/`DM_BU` from `dm_pkg`.
- `addr`, in, 32: byte address.
- `wdata`, in, 32: store data, right-aligned in the low bits.
- `pc`, in, 32: PC of the requesting instruction, used for the trace only.
- `ready`, out, 1: block idle; a request may be accepted this cycle.
- `rvalid`, out, 1: one-cycle response pulse, issued for loads and stores.
- `rdata`, out, 32: extended load result; 0 for stores and errors.
- `err`, out, 1: valid with `rvalid`; misaligned or out-of-range access.

## Operation
- FSM states: CLEAR, IDLE, BUSY, RESP.
  - Reset asserted → CLEAR, `clr_idx`=0.
- CLEAR:
  - Writes zero to `mem[clr_idx]` and increments `clr_idx` each cycle.
  - After index `CLEAR_WORDS-1` the FSM goes to IDLE.
  - `ready`=0 throughout CLEAR.
- IDLE:
  - `ready`=1.
  - `req`=1 latches `we`, `op`, `addr`, `wdata` and `pc`, and loads `cnt`=`LATENCY-1`.
  - Goes to RESP if `LATENCY`=1, otherwise to BUSY.
- BUSY:
  - `cnt` decrements each cycle.
  - At `cnt`=1 the FSM goes to RESP.
  - Incoming `req` is ignored.
- RESP:
  - `rvalid`=1 for exactly one cycle.
  - A store commits to memory on this edge.
  - Returns to IDLE.
- Word index is `addr[ADDR_W+1:2]`, where `ADDR_W` = clog2(`DEPTH_WORDS`).
- Out of range: any of `addr[31:ADDR_W+2]` nonzero.
- Misaligned:
  - `DM_W` with `addr[1:0]`≠0.
  - `DM_H`/`DM_HU` with `addr[0]`=1.
- On misaligned or out-of-range access: `err`=1, no write, `rdata`=0.
- Store merge: `sb` replaces the byte lane `addr[1:0]` with `wdata[7:0]`; `sh` replaces halfword lane `addr[1]` with `wdata[15:0]`; other lanes are kept.
- Load extension:
  - `DM_B`: sign-extend the selected byte.
  - `DM_BU`: zero-extend the selected byte.
  - `DM_H`/`DM_HU`: the same rule applied to the selected halfword.
- An undefined `op` behaves as `DM_W`.
- Memory is not initialised outside the clear sweep; words at index ≥ `CLEAR_WORDS` keep their contents across reset.

## Timing
- Reset values: `ready`=0, `rvalid`=0, `rdata`=0, `err`=0; FSM in CLEAR.
- Reset asserted mid-access: the access is abandoned, no partial write occurs, and the clear sweep restarts.
- Minimum period from reset release to first `ready`=1 is `CLEAR_WORDS` cycles.
- Request accepted at edge N → `rvalid` high during cycle N+`LATENCY`.
- The next `ready` comes one cycle after the response.
- Throughput is one access per `LATENCY`+1 cycles.
- Outputs are registered; `rdata` and `err` hold their value only while `rvalid`=1 and are 0 otherwise.
- A load that follows a store to the same word sees the merged data, because the store committed at RESP.

## Configuration
- `DM_TRACE_EN` defined: on every committed store, print `"%d@%h: *%h <= %h"` with `$time`, `pc+PC_OFFSET`, the word-aligned `addr`, and the merged 32-bit word. No line is printed for errored stores.
- Undefined: no display statements; synthesis-clean.

## Structure
- `dm_pkg` holds:
  - the `op` encodings `DM_W`=0, `DM_H`=1, `DM_HU`=2, `DM_B`=3, `DM_BU`=4;
  - the FSM state typedef;
  - the function `dm_is_misaligned(op, addr[1:0])`.
- One sub-module, `dm_lane_align`: combinational store-merge and load-extract/extend, shared by the merge and read paths.

## Test plan
- Reset release, `CLEAR_WORDS`=8, a word preloaded to 32'hDEADBEEF at index 3 → `ready` rises after 8 cycles; `lw` 0xC returns 0.
- `sw` 0x10 ← 32'h12345678, then `sb` 0x11 ← 32'hAB → `lw` 0x10 returns 32'h1234AB78; with `DM_TRACE_EN`, the trace shows `*00000010 <= 1234ab78`.
- Word 0x20 = 32'h80FF7F01:
  - `lb` 0x22 → 32'hFFFFFFFF;
  - `lbu` 0x23 → 32'h00000080;
  - `lh` 0x22 → 32'hFFFF80FF;
  - `lhu` 0x20 → 32'h00007F01.
- `sh` to 0x21, and `sw` to address `DEPTH_WORDS*4` → `rvalid`=1 with `err`=1; memory unchanged.
- `LATENCY`=3: `req` at edge N, with `req` held high → exactly one `rvalid` at N+3, `ready`=0 during N+1..N+3.
- `reset_n` pulsed low while in BUSY on a store → target word unchanged and the FSM restarts in CLEAR.
